// File: rtl/sram_access_controller.sv
// sram_access_controller
//
// Purpose: multi-cycle sequencer that replaces the single-cycle MEM-stage data
// memory with an external 16-bit asynchronous SRAM. Each 32-bit load or store
// is split into a LOW half-access followed by a HIGH half-access. Each half
// lasts WAIT_CYCLES clock cycles. While an access is in flight, `ready` is held
// low to freeze the pipeline.
//
// Optional feature macro: SRAM_ADDR_CHECK_EN
//   defined   - requests below MEM_BASE, beyond the 18-bit SRAM space or
//               misaligned set a sticky `err` and complete with no SRAM
//               strobes.
//   undefined - `err` is tied to 0 and out-of-range offsets wrap.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   MEM_R_EN     load request
//   MEM_W_EN     store request (wins over MEM_R_EN)
//   address      32-bit byte address (word aligned)
//   writeData    32-bit store data
//   readData     last completed load data (registered)
//   ready        high: MEM stage may advance; low: freeze
//   err          sticky range error (0 unless SRAM_ADDR_CHECK_EN)
//   SRAM_ADDR    18-bit SRAM half-word address
//   SRAM_DQ_OUT  write data to the pad
//   SRAM_DQ_OE   pad output enable
//   SRAM_DQ_IN   read data from the pad
//   SRAM_WE_N    active-low SRAM write enable
module sram_access_controller #(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] MEM_BASE    = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        err,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_OE,
  input  logic [15:0] SRAM_DQ_IN,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_store_q;
  logic [15:0] wdata_hi_q;
  logic [15:0] hold_lo_q;
  logic [31:0] read_data_q;
  logic [17:0] sram_addr_q;
  logic [15:0] dq_out_q;

  logic        req;
  logic        last;
  logic        active;
  logic        addr_bad;
  logic [16:0] off_word;

  assign req      = MEM_R_EN | MEM_W_EN;
  assign last     = (cnt_q == LAST_CNT);
  assign active   = (state_q == LOW) || (state_q == HIGH);
  // Word index inside the SRAM: byte offset from MEM_BASE, bits [18:2].
  assign off_word = 17'((address - MEM_BASE) >> 2);

`ifdef SRAM_ADDR_CHECK_EN
  logic [31:0] off_full;
  logic        err_q;

  assign off_full = address - MEM_BASE;
  assign addr_bad = (address < MEM_BASE) | (|(off_full >> 19)) | (|address[1:0]);
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && req && addr_bad) begin
      err_q <= 1'b1;
    end
  end
`else
  assign addr_bad = 1'b0;
  assign err      = 1'b0;
`endif

  // Next-state logic and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = 4'd0;
          // A rejected request completes immediately without touching the SRAM.
          state_d = addr_bad ? DONE : LOW;
        end
      end
      LOW: begin
        if (last) begin
          state_d = HIGH;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The strobes are decoded from registered state. An asynchronous reset
  // therefore releases them at once, without waiting for a clock edge.
  // WE_N is lifted on the last cycle of each half. This keeps the address
  // and data stable past the rising write-enable edge.
  assign SRAM_DQ_OE  = active & is_store_q;
  assign SRAM_WE_N   = ~(active & is_store_q & ~last);
  assign ready       = ((state_q == IDLE) & ~req) | (state_q == DONE);
  assign readData    = read_data_q;
  assign SRAM_ADDR   = sram_addr_q;
  assign SRAM_DQ_OUT = dq_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      is_store_q  <= 1'b0;
      wdata_hi_q  <= 16'd0;
      hold_lo_q   <= 16'd0;
      read_data_q <= 32'd0;
      sram_addr_q <= 18'd0;
      dq_out_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      case (state_q)
        IDLE: begin
          if (req && !addr_bad) begin
            // The store wins when both enables are asserted.
            is_store_q  <= MEM_W_EN;
            wdata_hi_q  <= writeData[31:16];
            sram_addr_q <= {off_word, 1'b0};
            if (MEM_W_EN) begin
              dq_out_q <= writeData[15:0];
            end
          end
        end
        LOW: begin
          if (last) begin
            hold_lo_q      <= SRAM_DQ_IN;
            sram_addr_q[0] <= 1'b1;
            if (is_store_q) begin
              dq_out_q <= wdata_hi_q;
            end
          end
        end
        HIGH: begin
          // The high half is taken straight from the pad on the same edge
          // that moves to DONE. readData is therefore valid throughout DONE.
          if (last && !is_store_q) begin
            read_data_q <= {SRAM_DQ_IN, hold_lo_q};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_controller.sv
module tb_sram_access_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r_en = 1'b0, w_en = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic        rdy, err;
  logic [17:0] sram_addr;
  logic [15:0] dq_out, dq_in;
  logic        dq_oe, we_n;

  // Instances used for the wait-state sweep.
  logic        r1 = 1'b0, r15 = 1'b0;
  logic        rdy1, rdy15, err1, err15, oe1, oe15, we1, we15;
  logic [31:0] rd1, rd15;
  logic [17:0] sa1, sa15;
  logic [15:0] do1, do15;
  logic [15:0] zero16;
  assign zero16 = 16'h0000;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_access_controller #(.WAIT_CYCLES(3), .MEM_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .address(addr),
    .writeData(wdata), .readData(rdata), .ready(rdy), .err(err),
    .SRAM_ADDR(sram_addr), .SRAM_DQ_OUT(dq_out), .SRAM_DQ_OE(dq_oe),
    .SRAM_DQ_IN(dq_in), .SRAM_WE_N(we_n)
  );

  sram_access_controller #(.WAIT_CYCLES(1), .MEM_BASE(32'd1024)) dut_w1 (
    .clk(clk), .rst(rst), .MEM_R_EN(r1), .MEM_W_EN(1'b0), .address(addr),
    .writeData(wdata), .readData(rd1), .ready(rdy1), .err(err1),
    .SRAM_ADDR(sa1), .SRAM_DQ_OUT(do1), .SRAM_DQ_OE(oe1),
    .SRAM_DQ_IN(zero16), .SRAM_WE_N(we1)
  );

  sram_access_controller #(.WAIT_CYCLES(15), .MEM_BASE(32'd1024)) dut_w15 (
    .clk(clk), .rst(rst), .MEM_R_EN(r15), .MEM_W_EN(1'b0), .address(addr),
    .writeData(wdata), .readData(rd15), .ready(rdy15), .err(err15),
    .SRAM_ADDR(sa15), .SRAM_DQ_OUT(do15), .SRAM_DQ_OE(oe15),
    .SRAM_DQ_IN(zero16), .SRAM_WE_N(we15)
  );

  // Bench SRAM model: 64 half-words. A write is taken at the negedge while
  // WE_N is low. Reset preloads the pattern A000+i.
  logic [15:0] mem [0:63];
  assign dq_in = mem[sram_addr[5:0]];

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'hA000 + 16'(i);
    end else if (!we_n) begin
      mem[sram_addr[5:0]] <= dq_out;
    end
  end

  // Launch one request and count the cycles with ready low, cycle 0 included.
  // The task returns in the ready-high cycle, which is sampled at its negedge.
  // It records the SRAM address in cycle 1 and in the last busy cycle. It
  // also records whether WE_N was ever seen low.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output int lowcnt,
                           output logic [17:0] a_first, output logic [17:0] a_last,
                           output logic we_low);
    @(posedge clk); #1;
    a_first = sram_addr;
    a_last  = sram_addr;
    we_low  = 1'b0;
    lowcnt  = 0;
    r_en = r; w_en = w; addr = a; wdata = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!we_n) we_low = 1'b1;
      if (rdy) break;
      if (i == 1) a_first = sram_addr;
      a_last = sram_addr;
      lowcnt++;
    end
  endtask

  task automatic release_req();
    @(posedge clk); #1;
    r_en = 1'b0; w_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", rdy); end
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_readData: got %h want 0", rdata); end
    n_checks++; if (sram_addr !== 18'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
    n_checks++; if (dq_out !== 16'd0) begin n_fail++; $display("FAIL reset_dqout: got %h want 0", dq_out); end
    n_checks++; if (dq_oe !== 1'b0 || we_n !== 1'b1) begin n_fail++; $display("FAIL reset_strobes: oe=%b we_n=%b want 0/1", dq_oe, we_n); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b1;
    // Start a store, then reset it mid-LOW while WE_N is asserted.
    @(posedge clk); #1;
    w_en = 1'b1; addr = 32'd1024; wdata = 32'h1111_2222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (we_n !== 1'b0 || dq_oe !== 1'b1) begin n_fail++; $display("FAIL midstore_strobes: we_n=%b oe=%b want 0/1", we_n, dq_oe); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (we_n !== 1'b1 || dq_oe !== 1'b0) begin n_fail++; $display("FAIL async_reset: we_n=%b oe=%b want 1/0", we_n, dq_oe); end
    w_en = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (rdy !== 1'b1 || rdata !== 32'd0) begin n_fail++; $display("FAIL post_reset: ready=%b readData=%h want 1/0", rdy, rdata); end
  endtask

  task automatic test_store_load();
    int lc; logic [17:0] af, al; logic wl;
    do_access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, lc, af, al, wl);
    n_checks++; if (lc !== 7) begin n_fail++; $display("FAIL store_latency: got %0d want 7", lc); end
    n_checks++; if (wl !== 1'b1) begin n_fail++; $display("FAIL store_we: got %b want 1", wl); end
    release_req();
    n_checks++; if (mem[0] !== 16'hBEEF) begin n_fail++; $display("FAIL store_word0: got %h want beef", mem[0]); end
    n_checks++; if (mem[1] !== 16'hDEAD) begin n_fail++; $display("FAIL store_word1: got %h want dead", mem[1]); end
    do_access(1'b1, 1'b0, 32'd1024, 32'd0, lc, af, al, wl);
    n_checks++; if (lc !== 7) begin n_fail++; $display("FAIL load_latency: got %0d want 7", lc); end
    n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_data: got %h want deadbeef", rdata); end
    n_checks++; if (wl !== 1'b0) begin n_fail++; $display("FAIL load_we: got %b want 0", wl); end
    release_req();
  endtask

  task automatic test_wait_sweep();
    int lc1, lc15;
    @(posedge clk); #1; addr = 32'd1024; r1 = 1'b1;
    lc1 = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (rdy1) break; lc1++; end
    @(posedge clk); #1; r1 = 1'b0;
    n_checks++; if (lc1 !== 3) begin n_fail++; $display("FAIL sweep_w1: ready low %0d want 3", lc1); end
    @(posedge clk); #1; r15 = 1'b1;
    lc15 = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (rdy15) break; lc15++; end
    @(posedge clk); #1; r15 = 1'b0;
    n_checks++; if (lc15 !== 31) begin n_fail++; $display("FAIL sweep_w15: ready low %0d want 31", lc15); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lc; logic [17:0] af, al; logic wl;
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, lc, af, al, wl);
    n_checks++; if (lc !== 7) begin n_fail++; $display("FAIL b2b1_latency: got %0d want 7", lc); end
    n_checks++; if (af !== 18'd2 || al !== 18'd3) begin n_fail++; $display("FAIL b2b1_addr: got %0d,%0d want 2,3", af, al); end
    n_checks++; if (rdata !== 32'hA003_A002) begin n_fail++; $display("FAIL b2b1_data: got %h want a003a002", rdata); end
    do_access(1'b1, 1'b0, 32'd1032, 32'd0, lc, af, al, wl);
    n_checks++; if (lc !== 7) begin n_fail++; $display("FAIL b2b2_latency: got %0d want 7", lc); end
    n_checks++; if (af !== 18'd4 || al !== 18'd5) begin n_fail++; $display("FAIL b2b2_addr: got %0d,%0d want 4,5", af, al); end
    n_checks++; if (rdata !== 32'hA005_A004) begin n_fail++; $display("FAIL b2b2_data: got %h want a005a004", rdata); end
    release_req();
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_dup: ready=%b want 1", rdy); end
  endtask

  task automatic test_both_enables();
    int lc; logic [17:0] af, al; logic wl;
    logic [31:0] prev;
    prev = 32'hA005_A004;
    do_access(1'b1, 1'b1, 32'd1036, 32'h1234_5678, lc, af, al, wl);
    n_checks++; if (wl !== 1'b1) begin n_fail++; $display("FAIL both_is_store: we_low=%b want 1", wl); end
    n_checks++; if (rdata !== prev) begin n_fail++; $display("FAIL both_readData: got %h want %h", rdata, prev); end
    release_req();
    n_checks++; if (mem[6] !== 16'h5678 || mem[7] !== 16'h1234) begin n_fail++; $display("FAIL both_mem: got %h,%h want 5678,1234", mem[6], mem[7]); end
  endtask

  task automatic test_range();
    int lc; logic [17:0] af, al; logic wl;
    logic [17:0] prev_addr;
    prev_addr = sram_addr;
    do_access(1'b1, 1'b0, 32'd512, 32'd0, lc, af, al, wl);
`ifdef SRAM_ADDR_CHECK_EN
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL range_err: got %b want 1", err); end
    n_checks++; if (lc !== 1) begin n_fail++; $display("FAIL range_latency: got %0d want 1", lc); end
    n_checks++; if (wl !== 1'b0) begin n_fail++; $display("FAIL range_we: got %b want 0", wl); end
    n_checks++; if (sram_addr !== prev_addr) begin n_fail++; $display("FAIL range_addr: got %h want %h", sram_addr, prev_addr); end
    n_checks++; if (rdata !== 32'hA005_A004) begin n_fail++; $display("FAIL range_readData: got %h want a005a004", rdata); end
`else
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b want 0 (prev addr %h)", err, prev_addr); end
    n_checks++; if (lc !== 7) begin n_fail++; $display("FAIL wrap_latency: got %0d want 7", lc); end
    n_checks++; if (af !== 18'h3FF00 || al !== 18'h3FF01) begin n_fail++; $display("FAIL wrap_addr: got %h,%h want 3ff00,3ff01", af, al); end
`endif
    release_req();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wait_sweep();
    test_back_to_back();
    test_both_enables();
    test_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_access_controller.md
# sram_access_controller

Multi-cycle sequencer between the MEM stage and an external 16-bit asynchronous SRAM. It accepts one 32-bit load or store per request (MEM_R_EN / MEM_W_EN from the control path), splits it into two 16-bit SRAM half-accesses with programmable wait states, and drives `ready` low to freeze the pipeline until the access completes. It sits in the MEM stage in place of the single-cycle data memory.

## Interface
- `WAIT_CYCLES`, default 3: cycles each 16-bit half-access occupies. Legal range is 1..15.
- `MEM_BASE`, default 1024: byte address mapped to SRAM word 0.
- `clk` input, 1 bit: the single clock. Everything is sampled on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `MEM_R_EN` input, 1 bit: load request.
- `MEM_W_EN` input, 1 bit: store request.
- `address` input, 32 bits: byte address, word-aligned.
- `writeData` input, 32 bits: store data.
- `readData` output, 32 bits: last completed load data. Registered.
- `ready` output, 1 bit: high means the MEM stage may advance. Low means freeze.
- `err` output, 1 bit: sticky range error. It exists only when `SRAM_ADDR_CHECK_EN` is defined; otherwise it is tied to 0.
- `SRAM_ADDR` output, 18 bits: SRAM half-word address.
- `SRAM_DQ_OUT` output, 16 bits: write data to the pad.
- `SRAM_DQ_OE` output, 1 bit: pad output enable.
- `SRAM_DQ_IN` input, 16 bits: read data from the pad.
- `SRAM_WE_N` output, 1 bit: active-low write enable.

## Operation
- **Request.** `req = MEM_R_EN | MEM_W_EN`. If both are asserted, the store wins and the load is ignored.
- **Address mapping.** `off = address - MEM_BASE` (32-bit, wrapping). `SRAM_ADDR = {off[18:2], half}`, where half is 0 in LOW and 1 in HIGH.
- **State machine: IDLE, LOW, HIGH, DONE.**
  - IDLE: when `req` is high, latch `address`, `writeData` and the request type, clear the counter, and go to LOW.
  - LOW: the counter counts 0..WAIT_CYCLES-1. At WAIT_CYCLES-1, go to HIGH and clear the counter.
  - HIGH: same counting. At WAIT_CYCLES-1, go to DONE.
  - DONE: unconditionally go to IDLE.
- **Store.**
  - In LOW, `SRAM_DQ_OUT` = `writeData[15:0]`, `SRAM_DQ_OE` = 1 and `SRAM_WE_N` = 0.
  - In HIGH, `SRAM_DQ_OUT` = `writeData[31:16]`, with the same enables.
  - On the last cycle of each half (counter = WAIT_CYCLES-1), `SRAM_WE_N` = 1 so the address is held past the write-enable edge.
- **Load.**
  - `SRAM_DQ_OE` = 0 and `SRAM_WE_N` = 1 throughout.
  - `SRAM_DQ_IN` is captured into the low half of a holding register on the last LOW cycle.
  - `SRAM_DQ_IN` is captured into the high half on the last HIGH cycle.
  - `readData` is updated from the holding register on entry to DONE.
- **`readData` retention.** `readData` holds its value through stores and idle periods. Only a completed load updates it.
- **`ready`.** `ready = (IDLE & ~req) | DONE`. It is combinational from the state and `req`.
- **Outside LOW/HIGH.** `SRAM_WE_N` = 1, `SRAM_DQ_OE` = 0, and `SRAM_ADDR` holds its last value.

## Timing
- **Reset values.**
  - State IDLE, counter 0.
  - `readData` = 0, `SRAM_ADDR` = 0, `SRAM_DQ_OUT` = 0.
  - `SRAM_DQ_OE` = 0, `SRAM_WE_N` = 1, `err` = 0.
  - `ready` = 1 while `req` is low.
- **Latency.** With the request first seen at cycle 0:
  - `ready` is low for cycles 0..2·WAIT_CYCLES.
  - `ready` is high in cycle 2·WAIT_CYCLES+1, which is DONE.
  - `readData` is valid in that same cycle.
  - With the default WAIT_CYCLES of 3, `ready` is high at cycle 7.
- **Back-to-back requests.** The pipeline advances in DONE. The next instruction's request is evaluated in IDLE the following cycle, so there is no lost or duplicated access.
- **Request changes mid-access.** Inputs are ignored once they are latched, so a mid-access change has no effect.
- **Reset mid-access.** Reset takes effect immediately and asynchronously: `SRAM_WE_N` goes to 1 and `SRAM_DQ_OE` goes to 0 without waiting for a clock, and the partial access is abandoned.
- **Boundary.** An `off` value with bits [31:19] nonzero wraps into the 18-bit space, unless the check below is compiled in.

## Configuration
- Macro: `SRAM_ADDR_CHECK_EN`.
- **Defined:**
  - In IDLE, a request with `address < MEM_BASE`, or with `off[31:19]` nonzero, or with `address[1:0]` nonzero, sets `err` (sticky until reset).
  - That request skips LOW and HIGH and goes directly to DONE. `ready` is low for 1 cycle.
  - No SRAM strobes are issued and `readData` is unchanged.
- **Undefined:**
  - `err` is constant 0.
  - Every request performs the full access, with address wrapping as described under Timing.

## Test plan
- **Reset.** Assert `rst`=0 mid-store during LOW → `SRAM_WE_N`=1 and `SRAM_DQ_OE`=0 immediately. After release, state is IDLE, `ready`=1 and `readData`=0.
- **Store then load.** Store 0xDEADBEEF to 1024, then load from 1024 (WAIT_CYCLES=3) against a bench SRAM model.
  - SRAM word 0 = 0xBEEF and word 1 = 0xDEAD.
  - The load returns 0xDEADBEEF, with `ready` high at cycle 7 of the load.
- **Wait-state sweep.** Run with WAIT_CYCLES=1 and WAIT_CYCLES=15 → `ready` is low for exactly 3 and 31 cycles respectively.
- **Back-to-back loads.** Loads from 1028 and then 1032, with `req` held continuously → exactly two 2-half accesses, separated by one DONE and one IDLE cycle. Addresses driven are 2,3 then 4,5.
- **Both enables asserted.** `MEM_R_EN`=`MEM_W_EN`=1 → a store is performed and `readData` is unchanged.
- **Range check (`SRAM_ADDR_CHECK_EN` defined).** Load from address 512 → `err`=1, `ready` low for 1 cycle, `SRAM_WE_N` never 0 and `SRAM_ADDR` unchanged.
